// File: rtl/bcd_field_writer_if.sv
// Bus bundle for bcd_field_writer: request side, converter side and char RAM write port.
// master = client/environment side, slave = bcd_field_writer.
interface bcd_field_writer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req;
  logic [15:0]       value;
  logic [4:0]        row;
  logic [6:0]        col;
  logic              busy;
  logic              done;
  logic              err;
  logic              conv_start;
  logic [15:0]       conv_bin;
  logic              conv_busy;
  logic              conv_done;
  logic [3:0]        conv_d4;
  logic [3:0]        conv_d3;
  logic [3:0]        conv_d2;
  logic [3:0]        conv_d1;
  logic [3:0]        conv_d0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output req, value, row, col, conv_busy, conv_done,
    output conv_d4, conv_d3, conv_d2, conv_d1, conv_d0,
    input  busy, done, err, conv_start, conv_bin, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, value, row, col, conv_busy, conv_done,
    input  conv_d4, conv_d3, conv_d2, conv_d1, conv_d0,
    output busy, done, err, conv_start, conv_bin, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bcd_field_writer.sv
// Converts a 16-bit value via the external double-dabble block and writes the five
// digits as ASCII into the text char RAM at (row, col), most significant digit first.
// Optional: define BCD_FIELD_BLANK_EN to blank leading zeros (d4..d1) as spaces.
module bcd_field_writer #(
  parameter int unsigned COLS    = 80,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  bcd_field_writer_if.slave bus
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StKick, StWait, StWrite, StFin} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              start_q, start_d, wr_en_q, wr_en_d;
  logic [15:0]       bin_q, bin_d;
  logic [4:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [2:0]        slot_q, slot_d;
  logic [4:0][3:0]   dig_q, dig_d;

  logic              emit;
  logic [2:0]        emit_slot;
  logic [3:0]        cur_digit;
  logic [ADDR_W-1:0] base;
  logic [7:0]        col_i;
  logic              in_row;
  logic [7:0]        char_val;

  // Slot 0 goes out in the conv_done cycle straight from the converter digits.
  assign emit_slot = (state_q == StWait) ? 3'd0 : slot_q;
  assign cur_digit = (state_q == StWait) ? bus.conv_d4 :
                     (slot_q < 3'd5)     ? dig_q[slot_q] : 4'd0;
  assign base      = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign col_i     = {1'b0, col_q} + {5'd0, emit_slot};
  // Slots past the row end are clipped, not wrapped.
  assign in_row    = 32'(col_i) < COLS;

`ifdef BCD_FIELD_BLANK_EN
  logic lead_q, lead_d, blank;

  // Leading-zero run persists only while every digit so far is zero; units never blank.
  always_comb begin
    blank    = ((state_q == StWait) || lead_q) && (cur_digit == 4'd0) && (emit_slot != 3'd4);
    lead_d   = emit ? blank : lead_q;
    char_val = blank ? 8'h20 : (8'h30 + {4'h0, cur_digit});
  end

  // Leading-zero tracking register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lead_q <= 1'b0;
    else        lead_q <= lead_d;
  end
`else
  assign char_val = 8'h30 + {4'h0, cur_digit};
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    start_d = 1'b0;
    wr_en_d = 1'b0;
    bin_d   = bin_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wd_d    = wd_q;
    slot_d  = slot_q;
    dig_d   = dig_q;
    emit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          bin_d   = bus.value;
          row_d   = bus.row;
          col_d   = bus.col;
          busy_d  = 1'b1;
          state_d = StKick;
        end
      end
      StKick: begin
        if (32'(row_q) >= ROWS) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else if (!bus.conv_busy) begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // conv_done takes priority over an expiring watchdog.
        if (bus.conv_done) begin
          dig_d   = {bus.conv_d0, bus.conv_d1, bus.conv_d2, bus.conv_d3, bus.conv_d4};
          emit    = 1'b1;
          slot_d  = 3'd1;
          state_d = StWrite;
        end else if (32'(wd_q) + 32'd1 >= TIMEOUT) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StWrite: begin
        if (slot_q < 3'd5) begin
          emit   = 1'b1;
          slot_d = slot_q + 3'd1;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (emit) begin
      wr_en_d = in_row;
      addr_d  = base + ADDR_W'(emit_slot);
      data_d  = char_val;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      wr_en_q <= 1'b0;
      bin_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      slot_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      wr_en_q <= wr_en_d;
      bin_q   <= bin_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      slot_q  <= slot_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.conv_start = start_q;
  assign bus.conv_bin   = bin_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;

endmodule

// File: tb/tb_bcd_field_writer.sv
// Scoreboard bench for bcd_field_writer with a behavioural converter stub.
module tb_bcd_field_writer;
  localparam int unsigned COLS    = 80;
  localparam int unsigned ROWS    = 30;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_field_writer_if #(.ADDR_W(ADDR_W)) bus ();

  bcd_field_writer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t wq[$];
  bit  dq[$];
  int  n_pass = 0, n_total = 0;
  int  cyc = 0;
  int  done_cnt = 0, last_done_cyc = 0, cd_cyc = 0;
  bit  cd_valid = 0;
  bit  mute = 0;
  int  stray_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Reference: digit k of value is (value / 10^(4-k)) % 10; leading blanks where value < 10^(4-k).
  function automatic void push_expect(input int value, input int row, input int col, input bit err);
    wr_t e;
    if (err) begin
      dq.push_back(1'b1);
      return;
    end
    for (int i = 0; i < 5; i++) begin
      int w = 1;
      for (int k = 0; k < 4 - i; k++) w *= 10;
      e.data = 8'(8'h30 + (value / w) % 10);
`ifdef BCD_FIELD_BLANK_EN
      if (i < 4 && value < w) e.data = 8'h20;
`endif
      e.addr = ADDR_W'(row * COLS + col + i);
      if (col + i < COLS) wq.push_back(e);
    end
    dq.push_back(1'b0);
  endfunction

  // Converter stub: random busy hold after req, random conversion latency.
  initial begin
    int cnt = 0, hold = 0, stray_ack = 0;
    bit s_start, s_req;
    logic [15:0] s_bin, pend;
    pend = '0;
    bus.conv_busy = 0; bus.conv_done = 0;
    bus.conv_d4 = 0; bus.conv_d3 = 0; bus.conv_d2 = 0; bus.conv_d1 = 0; bus.conv_d0 = 0;
    forever begin
      @(negedge clk);
      s_start = bus.conv_start;
      s_req   = bus.req;
      s_bin   = bus.conv_bin;
      @(posedge clk); #1;
      bus.conv_done = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.conv_d4 = 4'(pend / 10000 % 10);
          bus.conv_d3 = 4'(pend / 1000 % 10);
          bus.conv_d2 = 4'(pend / 100 % 10);
          bus.conv_d1 = 4'(pend / 10 % 10);
          bus.conv_d0 = 4'(pend % 10);
          bus.conv_done = 1;
        end
      end
      if (hold > 0) hold--;
      if (s_req && !mute) hold = $urandom_range(0, 3);
      if (s_start && !mute) begin
        cnt  = $urandom_range(1, 6);
        pend = s_bin;
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        bus.conv_d4 = 4'($urandom_range(0, 9));
        bus.conv_done = 1;
      end
      bus.conv_busy = (hold > 0) || (cnt > 0);
    end
  end

  // Monitor: pops and compares whenever the DUT writes or completes.
  initial begin
    wr_t e;
    bit  ee;
    forever begin
      @(negedge clk);
      if (!rst_n) cd_valid = 0;
      else begin
        if (bus.conv_done) begin
          cd_cyc   = cyc;
          cd_valid = 1;
        end
        if (bus.wr_en) begin
          chk("wr_expected", int'(wq.size() > 0), 1);
          if (wq.size() > 0) begin
            e = wq.pop_front();
            chk("wr_addr", bus.wr_addr, e.addr);
            chk("wr_data", bus.wr_data, e.data);
          end
        end
        if (bus.done) begin
          chk("done_expected", int'(dq.size() > 0), 1);
          if (dq.size() > 0) begin
            ee = dq.pop_front();
            chk("err", bus.err, ee);
          end
          chk("busy_at_done", bus.busy, 0);
          chk("wr_drained", wq.size(), 0);
          if (cd_valid) chk("done_lat", cyc - cd_cyc, 6);
          cd_valid      = 0;
          last_done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic do_txn(input int value, input int row, input int col,
                        input bit tmo, input bit mid_req);
    int t0, start;
    start = done_cnt;
    push_expect(value, row, col, (row >= int'(ROWS)) || tmo);
    mute = tmo;
    @(posedge clk); #1;
    bus.req = 1; bus.value = 16'(value); bus.row = 5'(row); bus.col = 7'(col);
    t0 = cyc;
    @(posedge clk); #1;
    bus.req = 0; bus.value = 16'($urandom); bus.row = 5'($urandom); bus.col = 7'($urandom);
    @(negedge clk);
    chk("busy_after_req", bus.busy, 1);
    if (mid_req) begin
      repeat (10) @(posedge clk);
      #1;
      bus.req = 1; bus.value = 16'h1234; bus.row = 5'd1; bus.col = 7'd1;
      @(posedge clk); #1;
      bus.req = 0;
    end
    for (int k = 0; k < 300 && done_cnt == start; k++) @(negedge clk);
    chk("done_seen", done_cnt - start, 1);
    if (row >= int'(ROWS)) chk("rowerr_lat", last_done_cyc - t0, 2);
    else if (tmo) chk("timeout_lat", last_done_cyc - t0, 66);
    mute = 0;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_conv_start"}, bus.conv_start, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_conv_bin"}, bus.conv_bin, 0);
  endtask

  // Reset during the third write slot, then a stray conv_done that must be ignored.
  task automatic reset_mid_write();
    int k;
    push_expect(54321, 4, 20, 1'b0);
    @(posedge clk); #1;
    bus.req = 1; bus.value = 16'd54321; bus.row = 5'd4; bus.col = 7'd20;
    @(posedge clk); #1;
    bus.req = 0;
    for (k = 0; k < 100 && !bus.conv_done; k++) @(negedge clk);
    chk("reset_test_conv_done", bus.conv_done, 1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk_reset_state("mid_reset");
    wq.delete();
    dq.delete();
    @(posedge clk); #1;
    rst_n = 1;
    stray_req++;
    repeat (12) @(negedge clk);
    chk("stray_no_busy", bus.busy, 0);
  endtask

  initial begin
    bus.req = 0; bus.value = 0; bus.row = 0; bus.col = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1;

    do_txn(12345, 2, 10, 0, 0);
    do_txn(65535, 0, 77, 0, 0);
    do_txn(7, 1, 0, 0, 0);
    do_txn(0, 3, 5, 0, 0);
    do_txn(500, 30, 0, 0, 0);
    do_txn(99, 31, 3, 0, 0);
    do_txn(1000, 29, 79, 0, 0);
    do_txn(4242, 7, 100, 0, 0);
    do_txn(40, 1, 1, 1, 1);
    for (int n = 0; n < 40; n++) begin
      int r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 31)) : int'($urandom_range(0, 29));
      int c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(74, 127)) : int'($urandom_range(0, 79));
      do_txn(int'($urandom_range(0, 65535)), r, c, 0, 0);
    end
    reset_mid_write();
    do_txn(4321, 5, 60, 0, 0);

    repeat (5) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
